// File: rtl/instruction_fetch.sv
// instruction_fetch: IF stage of the 3-bit CPU; serial program load, PC stepping by 2, JNZ redirect.
// Define IF_BREAKPOINT_EN to add bp_en/bp_addr/bp_hit and the PAUSE state.
module instruction_fetch #(
  parameter int PROG_DEPTH = 16,
  parameter int PC_W       = $clog2(PROG_DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            prog_wr_en,
  input  logic [2:0]      prog_wr_data,
  input  logic            clear,
  input  logic            start,
  input  logic            halt_if,
  input  logic            jump_taken,
  input  logic [2:0]      jump_target,
`ifdef IF_BREAKPOINT_EN
  input  logic            bp_en,
  input  logic [PC_W-1:0] bp_addr,
  output logic            bp_hit,
`endif
  output logic [2:0]      opcode_if_reg,
  output logic [2:0]      operand_if_reg,
  output logic            valid_if,
  output logic [PC_W-1:0] pc_if_reg,
  output logic            flush_o,
  output logic            fetch_done
);

  localparam int              AW      = $clog2(PROG_DEPTH);
  localparam logic [PC_W-1:0] DEPTH_L = PC_W'(PROG_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
`ifdef IF_BREAKPOINT_EN
  localparam logic [1:0] S_PAUSE = 2'd3;
`endif

  logic [1:0]      r_state;
  logic [1:0]      w_state_next;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] r_load_ptr;
  logic [PC_W-1:0] w_pc_plus1;
  logic [PC_W-1:0] w_target;
  logic [2:0]      r_mem [PROG_DEPTH];
  logic            w_write;
  logic            w_jump;
  logic            w_restart;
  logic            w_fetch;
  logic            w_hold;
`ifdef IF_BREAKPOINT_EN
  logic            r_bp_skip;
  logic            w_resume;
  logic            w_slot;
`endif

  // load pointer doubles as program length; it saturates at PROG_DEPTH
  assign w_pc_plus1 = r_pc + PC_W'(1);
  assign w_target   = PC_W'(jump_target);
  assign w_write    = (r_state == S_IDLE) && prog_wr_en && !clear && (r_load_ptr != DEPTH_L);
  assign w_hold     = (r_state == S_RUN) && halt_if && !jump_taken;
`ifdef IF_BREAKPOINT_EN
  assign w_slot     = (r_state == S_RUN) && !jump_taken && !halt_if;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_jump       = 1'b0;
    w_restart    = 1'b0;
    w_fetch      = 1'b0;
`ifdef IF_BREAKPOINT_EN
    w_resume     = 1'b0;
`endif
    if (clear) begin
      w_state_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start && !prog_wr_en) begin
            if (r_load_ptr >= PC_W'(2)) begin
              w_state_next = S_RUN;
              w_restart    = 1'b1;
            end else begin
              w_state_next = S_DONE;
            end
          end
        end
        S_RUN: begin
          if (jump_taken) begin
            w_jump = 1'b1;
          end else if (!halt_if) begin
`ifdef IF_BREAKPOINT_EN
            if (bp_en && (r_pc == bp_addr) && !r_bp_skip) w_state_next = S_PAUSE;
            else
`endif
            if (w_pc_plus1 < r_load_ptr) w_fetch = 1'b1;
            else                         w_state_next = S_DONE;
          end
        end
        S_DONE: begin
          // a JNZ that was the last instruction resolves after IF ran off the end
          if (jump_taken) begin
            w_jump       = 1'b1;
            w_state_next = S_RUN;
          end else if (start) begin
            w_restart    = 1'b1;
            w_state_next = S_RUN;
          end
        end
`ifdef IF_BREAKPOINT_EN
        S_PAUSE: begin
          if (jump_taken) begin
            w_jump       = 1'b1;
            w_state_next = S_RUN;
          end else if (start) begin
            w_resume     = 1'b1;
            w_state_next = S_RUN;
          end
        end
`endif
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    fetch_done = (r_state == S_DONE);
`ifdef IF_BREAKPOINT_EN
    bp_hit     = (r_state == S_PAUSE);
`endif
  end

  always_ff @(posedge clk) begin
    if (w_write) r_mem[r_load_ptr[AW-1:0]] <= prog_wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc           <= '0;
      r_load_ptr     <= '0;
      opcode_if_reg  <= '0;
      operand_if_reg <= '0;
      pc_if_reg      <= '0;
      valid_if       <= 1'b0;
      flush_o        <= 1'b0;
    end else if (clear) begin
      r_pc           <= '0;
      r_load_ptr     <= '0;
      opcode_if_reg  <= '0;
      operand_if_reg <= '0;
      pc_if_reg      <= '0;
      valid_if       <= 1'b0;
      flush_o        <= 1'b0;
    end else begin
      flush_o <= w_jump;
      if (w_write) r_load_ptr <= r_load_ptr + PC_W'(1);
      if (w_jump) begin
        r_pc     <= w_target;
        valid_if <= 1'b0;
      end else if (w_restart) begin
        r_pc     <= '0;
        valid_if <= 1'b0;
      end else if (w_fetch) begin
        opcode_if_reg  <= r_mem[r_pc[AW-1:0]];
        operand_if_reg <= r_mem[w_pc_plus1[AW-1:0]];
        pc_if_reg      <= r_pc;
        valid_if       <= 1'b1;
        r_pc           <= r_pc + PC_W'(2);
      end else if (!w_hold) begin
        valid_if <= 1'b0;
      end
    end
  end

`ifdef IF_BREAKPOINT_EN
  // skip flag lets the resumed fetch pass the breakpoint address exactly once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          r_bp_skip <= 1'b0;
    else if (clear || w_jump || w_restart) r_bp_skip <= 1'b0;
    else if (w_resume)                   r_bp_skip <= 1'b1;
    else if (w_slot)                     r_bp_skip <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios plus randomized runs
// against a pair-stream reference model.
module tb_instruction_fetch;
  localparam int PROG_DEPTH = 16;
  localparam int PC_W       = 5;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            prog_wr_en = 1'b0;
  logic [2:0]      prog_wr_data = '0;
  logic            clear = 1'b0;
  logic            start = 1'b0;
  logic            halt_if = 1'b0;
  logic            jump_taken = 1'b0;
  logic [2:0]      jump_target = '0;
  logic [2:0]      opcode_if_reg;
  logic [2:0]      operand_if_reg;
  logic            valid_if;
  logic [PC_W-1:0] pc_if_reg;
  logic            flush_o;
  logic            fetch_done;
`ifdef IF_BREAKPOINT_EN
  logic            bp_en = 1'b0;
  logic [PC_W-1:0] bp_addr = '0;
  logic            bp_hit;
`endif

  int checks = 0;
  int errors = 0;
  int m_prog [PROG_DEPTH];

  instruction_fetch #(.PROG_DEPTH(PROG_DEPTH), .PC_W(PC_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .prog_wr_en(prog_wr_en), .prog_wr_data(prog_wr_data),
    .clear(clear), .start(start), .halt_if(halt_if),
    .jump_taken(jump_taken), .jump_target(jump_target),
`ifdef IF_BREAKPOINT_EN
    .bp_en(bp_en), .bp_addr(bp_addr), .bp_hit(bp_hit),
`endif
    .opcode_if_reg(opcode_if_reg), .operand_if_reg(operand_if_reg),
    .valid_if(valid_if), .pc_if_reg(pc_if_reg),
    .flush_o(flush_o), .fetch_done(fetch_done)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic j, input logic h, input logic [2:0] t);
    jump_taken = j; halt_if = h; jump_target = t;
    step();
    jump_taken = 1'b0; halt_if = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1; step(); clear = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic load(input int n);
    for (int i = 0; i < n; i++) begin
      prog_wr_en   = 1'b1;
      prog_wr_data = (i < PROG_DEPTH) ? 3'(m_prog[i]) : 3'($urandom_range(0, 7));
      step();
    end
    prog_wr_en = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (opcode_if_reg !== 3'd0) begin errors++; $display("FAIL reset_opcode got %0d want 0", opcode_if_reg); end
    checks++; if (operand_if_reg !== 3'd0) begin errors++; $display("FAIL reset_operand got %0d want 0", operand_if_reg); end
    checks++; if (valid_if !== 1'b0) begin errors++; $display("FAIL reset_valid got %0d want 0", valid_if); end
    checks++; if (pc_if_reg !== '0) begin errors++; $display("FAIL reset_pc got %0d want 0", pc_if_reg); end
    checks++; if (flush_o !== 1'b0) begin errors++; $display("FAIL reset_flush got %0d want 0", flush_o); end
    checks++; if (fetch_done !== 1'b0) begin errors++; $display("FAIL reset_done got %0d want 0", fetch_done); end
    rst_n = 1'b1;
    step();
    checks++; if (fetch_done !== 1'b0 || valid_if !== 1'b0) begin errors++; $display("FAIL reset_idle got done=%0d valid=%0d want 0 0", fetch_done, valid_if); end
    $display("test_reset done");
  endtask

  task automatic test_basic();
    int exp_op [3]  = '{0, 5, 3};
    int exp_opr [3] = '{3, 4, 0};
    m_prog[0] = 0; m_prog[1] = 3; m_prog[2] = 5; m_prog[3] = 4; m_prog[4] = 3; m_prog[5] = 0;
    do_clear(); load(6); do_start();
    checks++; if (valid_if !== 1'b0) begin errors++; $display("FAIL basic_latency got valid=%0d want 0", valid_if); end
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 1'b0, 3'd0);
      $display("basic pair op=%0d opr=%0d pc=%0d valid=%0d", opcode_if_reg, operand_if_reg, pc_if_reg, valid_if);
      checks++; if (valid_if !== 1'b1) begin errors++; $display("FAIL basic_valid[%0d] got %0d want 1", k, valid_if); end
      checks++; if (opcode_if_reg !== 3'(exp_op[k])) begin errors++; $display("FAIL basic_op[%0d] got %0d want %0d", k, opcode_if_reg, exp_op[k]); end
      checks++; if (operand_if_reg !== 3'(exp_opr[k])) begin errors++; $display("FAIL basic_opr[%0d] got %0d want %0d", k, operand_if_reg, exp_opr[k]); end
      checks++; if (pc_if_reg !== PC_W'(2 * k)) begin errors++; $display("FAIL basic_pc[%0d] got %0d want %0d", k, pc_if_reg, 2 * k); end
      checks++; if (fetch_done !== 1'b0) begin errors++; $display("FAIL basic_done_early[%0d] got %0d want 0", k, fetch_done); end
    end
    cyc(1'b0, 1'b0, 3'd0);
    checks++; if (valid_if !== 1'b0) begin errors++; $display("FAIL basic_end_valid got %0d want 0", valid_if); end
    checks++; if (fetch_done !== 1'b1) begin errors++; $display("FAIL basic_end_done got %0d want 1", fetch_done); end
  endtask

  task automatic test_jump_from_done();
    cyc(1'b1, 1'b0, 3'd0);
    $display("jump_done flush=%0d valid=%0d done=%0d", flush_o, valid_if, fetch_done);
    checks++; if (flush_o !== 1'b1) begin errors++; $display("FAIL jdone_flush got %0d want 1", flush_o); end
    checks++; if (valid_if !== 1'b0) begin errors++; $display("FAIL jdone_bubble got %0d want 0", valid_if); end
    checks++; if (fetch_done !== 1'b0) begin errors++; $display("FAIL jdone_done got %0d want 0", fetch_done); end
    cyc(1'b0, 1'b0, 3'd0);
    checks++; if (flush_o !== 1'b0) begin errors++; $display("FAIL jdone_flush_pulse got %0d want 0", flush_o); end
    checks++; if ({valid_if, opcode_if_reg, operand_if_reg, pc_if_reg} !== {1'b1, 3'd0, 3'd3, 5'd0})
      begin errors++; $display("FAIL jdone_pair got v%0d (%0d,%0d)@%0d want v1 (0,3)@0", valid_if, opcode_if_reg, operand_if_reg, pc_if_reg); end
  endtask

  task automatic test_halt();
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 1'b1, 3'd0);
      checks++; if ({valid_if, opcode_if_reg, operand_if_reg, pc_if_reg, flush_o} !== {1'b1, 3'd0, 3'd3, 5'd0, 1'b0})
        begin errors++; $display("FAIL halt_freeze[%0d] got v%0d (%0d,%0d)@%0d f%0d want v1 (0,3)@0 f0", k, valid_if, opcode_if_reg, operand_if_reg, pc_if_reg, flush_o); end
    end
    cyc(1'b0, 1'b0, 3'd0);
    $display("halt resume op=%0d opr=%0d pc=%0d", opcode_if_reg, operand_if_reg, pc_if_reg);
    checks++; if ({valid_if, opcode_if_reg, operand_if_reg, pc_if_reg} !== {1'b1, 3'd5, 3'd4, 5'd2})
      begin errors++; $display("FAIL halt_next got v%0d (%0d,%0d)@%0d want v1 (5,4)@2", valid_if, opcode_if_reg, operand_if_reg, pc_if_reg); end
  endtask

  task automatic test_odd_length();
    m_prog[0] = 1; m_prog[1] = 7; m_prog[2] = 2; m_prog[3] = 4; m_prog[4] = 6;
    do_clear(); load(5); do_start();
    cyc(1'b0, 1'b0, 3'd0);
    checks++; if ({valid_if, opcode_if_reg, operand_if_reg, pc_if_reg} !== {1'b1, 3'd1, 3'd7, 5'd0})
      begin errors++; $display("FAIL odd_pair0 got v%0d (%0d,%0d)@%0d want v1 (1,7)@0", valid_if, opcode_if_reg, operand_if_reg, pc_if_reg); end
    cyc(1'b0, 1'b0, 3'd0);
    checks++; if ({valid_if, opcode_if_reg, operand_if_reg, pc_if_reg} !== {1'b1, 3'd2, 3'd4, 5'd2})
      begin errors++; $display("FAIL odd_pair1 got v%0d (%0d,%0d)@%0d want v1 (2,4)@2", valid_if, opcode_if_reg, operand_if_reg, pc_if_reg); end
    cyc(1'b0, 1'b0, 3'd0);
    checks++; if ({valid_if, fetch_done} !== 2'b01) begin errors++; $display("FAIL odd_end got valid=%0d done=%0d want 0 1", valid_if, fetch_done); end
    do_start();
    checks++; if ({valid_if, fetch_done} !== 2'b00) begin errors++; $display("FAIL odd_restart got valid=%0d done=%0d want 0 0", valid_if, fetch_done); end
    cyc(1'b0, 1'b0, 3'd0);
    $display("odd restart op=%0d opr=%0d pc=%0d", opcode_if_reg, operand_if_reg, pc_if_reg);
    checks++; if ({valid_if, opcode_if_reg, operand_if_reg, pc_if_reg} !== {1'b1, 3'd1, 3'd7, 5'd0})
      begin errors++; $display("FAIL odd_restart_pair got v%0d (%0d,%0d)@%0d want v1 (1,7)@0", valid_if, opcode_if_reg, operand_if_reg, pc_if_reg); end
  endtask

  task automatic test_short_and_collide();
    m_prog[0] = 6;
    do_clear(); load(1); do_start();
    checks++; if (fetch_done !== 1'b1) begin errors++; $display("FAIL short_done got %0d want 1", fetch_done); end
    do_clear();
    checks++; if (fetch_done !== 1'b0) begin errors++; $display("FAIL clear_idle got %0d want 0", fetch_done); end
    prog_wr_en = 1'b1; prog_wr_data = 3'd2; start = 1'b1;
    step();
    prog_wr_en = 1'b0; start = 1'b0;
    step();
    checks++; if ({fetch_done, valid_if} !== 2'b00) begin errors++; $display("FAIL collide_start got done=%0d valid=%0d want 0 0", fetch_done, valid_if); end
    $display("short/collide done");
  endtask

  task automatic test_saturate_jump_halt();
    for (int i = 0; i < PROG_DEPTH; i++) m_prog[i] = $urandom_range(0, 7);
    do_clear(); load(20); do_start();
    for (int k = 0; k < 8; k++) begin
      cyc(1'b0, 1'b0, 3'd0);
      checks++; if ({valid_if, opcode_if_reg, operand_if_reg, pc_if_reg} !== {1'b1, 3'(m_prog[2*k]), 3'(m_prog[2*k+1]), PC_W'(2*k)})
        begin errors++; $display("FAIL sat_pair[%0d] got v%0d (%0d,%0d)@%0d want v1 (%0d,%0d)@%0d", k, valid_if, opcode_if_reg, operand_if_reg, pc_if_reg, m_prog[2*k], m_prog[2*k+1], 2*k); end
    end
    cyc(1'b1, 1'b1, 3'd5);
    $display("sat jump+halt flush=%0d valid=%0d", flush_o, valid_if);
    checks++; if ({flush_o, valid_if, fetch_done} !== 3'b100) begin errors++; $display("FAIL sat_jump got f%0d v%0d d%0d want 1 0 0", flush_o, valid_if, fetch_done); end
    cyc(1'b0, 1'b0, 3'd0);
    checks++; if ({valid_if, opcode_if_reg, operand_if_reg, pc_if_reg} !== {1'b1, 3'(m_prog[5]), 3'(m_prog[6]), PC_W'(5)})
      begin errors++; $display("FAIL sat_target got v%0d (%0d,%0d)@%0d want v1 (%0d,%0d)@5", valid_if, opcode_if_reg, operand_if_reg, pc_if_reg, m_prog[5], m_prog[6]); end
  endtask

  task automatic test_random();
    int len, m_st, m_pc, e_pcif;
    logic [2:0] e_op, e_opr, t;
    logic e_valid, e_flush, j, h;
    e_op = '0; e_opr = '0; e_pcif = 0;
    for (int it = 0; it < 10; it++) begin
      len = $urandom_range(0, PROG_DEPTH);
      for (int i = 0; i < PROG_DEPTH; i++) m_prog[i] = $urandom_range(0, 7);
      do_clear(); load(len); do_start();
      m_st = (len >= 2) ? 1 : 2;  // 1 = running, 2 = done
      m_pc = 0; e_valid = 1'b0; e_flush = 1'b0;
      checks++; if ({fetch_done, valid_if} !== {(m_st == 2), 1'b0}) begin errors++; $display("FAIL rnd_start[%0d] got d%0d v%0d want d%0d v0", it, fetch_done, valid_if, m_st == 2); end
      for (int c = 0; c < 30; c++) begin
        j = ($urandom_range(0, 7) == 0);
        h = ($urandom_range(0, 3) == 0);
        t = 3'($urandom_range(0, 7));
        cyc(j, h, t);
        if (j) begin
          m_st = 1; m_pc = int'(t); e_valid = 1'b0; e_flush = 1'b1;
        end else begin
          e_flush = 1'b0;
          if (m_st == 1 && !h) begin
            if (m_pc + 1 < len) begin
              e_op = 3'(m_prog[m_pc]); e_opr = 3'(m_prog[m_pc+1]); e_pcif = m_pc; e_valid = 1'b1; m_pc += 2;
            end else begin
              m_st = 2; e_valid = 1'b0;
            end
          end else if (m_st == 2) begin
            e_valid = 1'b0;
          end
        end
        checks++;
        if ({valid_if, flush_o, fetch_done} !== {e_valid, e_flush, (m_st == 2)} ||
            (e_valid && {opcode_if_reg, operand_if_reg, pc_if_reg} !== {e_op, e_opr, PC_W'(e_pcif)})) begin
          errors++;
          $display("FAIL rnd[%0d.%0d] got v%0d f%0d d%0d (%0d,%0d)@%0d want v%0d f%0d d%0d (%0d,%0d)@%0d",
                   it, c, valid_if, flush_o, fetch_done, opcode_if_reg, operand_if_reg, pc_if_reg,
                   e_valid, e_flush, m_st == 2, e_op, e_opr, e_pcif);
        end
      end
      $display("random run %0d len=%0d checked", it, len);
    end
  endtask

`ifdef IF_BREAKPOINT_EN
  task automatic test_breakpoint();
    m_prog[0] = 0; m_prog[1] = 3; m_prog[2] = 5; m_prog[3] = 4; m_prog[4] = 3; m_prog[5] = 0;
    do_clear(); load(6);
    bp_en = 1'b1; bp_addr = PC_W'(2);
    do_start();
    cyc(1'b0, 1'b0, 3'd0);
    checks++; if ({valid_if, pc_if_reg} !== {1'b1, 5'd0}) begin errors++; $display("FAIL bp_first got v%0d @%0d want v1 @0", valid_if, pc_if_reg); end
    cyc(1'b0, 1'b0, 3'd0);
    checks++; if ({valid_if, bp_hit} !== 2'b01) begin errors++; $display("FAIL bp_pause got v%0d hit%0d want 0 1", valid_if, bp_hit); end
    do_start();
    cyc(1'b0, 1'b0, 3'd0);
    checks++; if ({valid_if, opcode_if_reg, operand_if_reg, pc_if_reg, bp_hit} !== {1'b1, 3'd5, 3'd4, 5'd2, 1'b0})
      begin errors++; $display("FAIL bp_resume got v%0d (%0d,%0d)@%0d hit%0d want v1 (5,4)@2 hit0", valid_if, opcode_if_reg, operand_if_reg, pc_if_reg, bp_hit); end
    bp_en = 1'b0;
    $display("breakpoint done");
  endtask
`endif

  task automatic test_async_reset();
    m_prog[0] = 6; m_prog[1] = 5; m_prog[2] = 1; m_prog[3] = 2;
    do_clear(); load(4); do_start();
    cyc(1'b0, 1'b0, 3'd0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if ({valid_if, opcode_if_reg, operand_if_reg, pc_if_reg} !== {1'b1, 3'd0, 3'd0, 5'd0} && valid_if !== 1'b0)
      begin errors++; $display("FAIL areset_valid got %0d want 0", valid_if); end
    checks++; if ({opcode_if_reg, operand_if_reg} !== 6'd0) begin errors++; $display("FAIL areset_pair got (%0d,%0d) want (0,0)", opcode_if_reg, operand_if_reg); end
    #2;
    rst_n = 1'b1;
    step();
    checks++; if ({valid_if, fetch_done} !== 2'b00) begin errors++; $display("FAIL areset_idle got v%0d d%0d want 0 0", valid_if, fetch_done); end
    $display("async reset done");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_jump_from_done();
    test_halt();
    test_odd_length();
    test_short_and_collide();
    test_saturate_jump_halt();
`ifdef IF_BREAKPOINT_EN
    test_breakpoint();
`endif
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
